// File: rtl/ntt_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_rom_sequencer
// Brief    : Walks a contiguous range of the NTT twiddle/index schedule ROM and
//            streams two butterfly ops per word over a valid/ready handshake.
//            Optional stall-cycle counter enabled by NTT_SEQ_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_rom_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8,
    parameter int ZETA_W = 12,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic              bf_lane,
    output logic [ZETA_W-1:0] bf_zeta,
    output logic [IDX_W-1:0]  bf_idx_a,
    output logic [IDX_W-1:0]  bf_idx_b,
    output logic              bf_last
`ifdef NTT_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int c_L0_ZETA_LSB = 48;
    localparam int c_L0_A_LSB    = 40;
    localparam int c_L0_B_LSB    = 32;
    localparam int c_L1_ZETA_LSB = 16;
    localparam int c_L1_A_LSB    = 8;
    localparam int c_L1_B_LSB    = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_ISSUE0 = 3'd3,
        S_ISSUE1 = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_rem, w_rem_nxt;
    logic [DATA_W-1:0] r_word, w_word_nxt;
    logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_nxt;
    logic              w_unused_word;

    // Nibbles above each lane's zeta field carry no information.
    assign w_unused_word = ^{r_word[63:60], r_word[31:28]};
    assign rom_addr      = r_rom_addr;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_word     <= '0;
            r_rom_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_word     <= w_word_nxt;
            r_rom_addr <= w_rom_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_word_nxt     = r_word;
        w_rom_addr_nxt = r_rom_addr;
        busy           = (r_state != S_IDLE);
        done           = 1'b0;
        bf_valid       = 1'b0;
        bf_lane        = 1'b0;
        bf_zeta        = '0;
        bf_idx_a       = '0;
        bf_idx_b       = '0;
        bf_last        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_rom_addr_nxt = base_addr;
                        w_rem_nxt      = count;
                        w_state_nxt    = S_WAIT;
                    end else begin
                        w_state_nxt    = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // Capture the first word and immediately prefetch the next one.
                w_word_nxt     = rom_dout;
                w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
                w_state_nxt    = S_ISSUE0;
            end
            S_ISSUE0: begin
                bf_valid = 1'b1;
                bf_lane  = 1'b0;
                bf_zeta  = r_word[c_L0_ZETA_LSB +: ZETA_W];
                bf_idx_a = r_word[c_L0_A_LSB +: IDX_W];
                bf_idx_b = r_word[c_L0_B_LSB +: IDX_W];
                if (bf_ready) begin
                    w_state_nxt = S_ISSUE1;
                end
            end
            S_ISSUE1: begin
                bf_valid = 1'b1;
                bf_lane  = 1'b1;
                bf_zeta  = r_word[c_L1_ZETA_LSB +: ZETA_W];
                bf_idx_a = r_word[c_L1_A_LSB +: IDX_W];
                bf_idx_b = r_word[c_L1_B_LSB +: IDX_W];
                bf_last  = (r_rem == CNT_W'(1));
                if (bf_ready) begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // rom_dout already holds the word prefetched one op earlier.
                        w_word_nxt     = rom_dout;
                        w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
                        w_state_nxt    = S_ISSUE0;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef NTT_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (bf_valid && !bf_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_rom_sequencer
// Brief    : Scoreboard bench for ntt_rom_sequencer with a behavioural ROM and
//            a word-level op model; honours NTT_SEQ_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_rom_sequencer;

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic [6:0]  base_addr;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic [6:0]  rom_addr;
    logic [63:0] rom_dout;
    logic        bf_valid;
    logic        bf_ready;
    logic        bf_lane;
    logic [11:0] bf_zeta;
    logic [7:0]  bf_idx_a;
    logic [7:0]  bf_idx_b;
    logic        bf_last;
`ifdef NTT_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    ntt_rom_sequencer dut (
        .clk       (clk),
        .srst      (srst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .bf_lane   (bf_lane),
        .bf_zeta   (bf_zeta),
        .bf_idx_a  (bf_idx_a),
        .bf_idx_b  (bf_idx_b),
        .bf_last   (bf_last)
`ifdef NTT_SEQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct packed {
        logic        lane;
        logic [11:0] zeta;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        last;
    } op_t;

    logic [63:0] rom [0:127];
    op_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          exp_first_cyc = -1;
    int          exp_done_cyc = -1;
    int          done_seen = 0;
    int          stall_model = 0;
    bit          first_seen = 1'b0;
    bit          stalled_prev = 1'b0;
    bit          rdy_rand = 1'b0;
    op_t         prev_op;
    op_t         mon_cur;
    op_t         mon_exp;

    // Behavioural ROM with one cycle of registered read latency
    always @(posedge clk) rom_dout <= rom[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: each word yields its upper-half op then its lower-half op.
    task automatic push_run(input logic [6:0] b, input int n);
        logic [63:0] word;
        logic [6:0]  a;
        for (int w = 0; w < n; w++) begin
            a    = b + 7'(w);
            word = rom[a];
            exp_q.push_back({1'b0, word[59:48], word[47:40], word[39:32], 1'b0});
            exp_q.push_back({1'b1, word[27:16], word[15:8], word[7:0], (w == n - 1)});
        end
    endtask

    initial begin
        bf_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bf_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    initial begin
        forever begin
            @(negedge clk);
            if (srst) begin
                stalled_prev = 1'b0;
            end else begin
                mon_cur = {bf_lane, bf_zeta, bf_idx_a, bf_idx_b, bf_last};
                if (stalled_prev)
                    check("stall_hold", {bf_valid, mon_cur}, {1'b1, prev_op});
                if (!bf_valid)
                    check("idle_outputs_zero", 64'(mon_cur), 64'd0);
                if (bf_valid && !first_seen) begin
                    first_seen = 1'b1;
                    if (exp_first_cyc >= 0)
                        check("first_valid_cycle", cyc, exp_first_cyc);
                end
                if (bf_valid && bf_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_op");
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("op", 64'(mon_cur), 64'(mon_exp));
                    end
                end
                if (bf_valid && !bf_ready)
                    stall_model++;
                stalled_prev = bf_valid && !bf_ready;
                prev_op      = mon_cur;
                if (done) begin
                    if (exp_done_cyc == -1) begin
                        fail_now("unexpected_done");
                    end else begin
                        if (exp_done_cyc >= 0)
                            check("done_cycle", cyc, exp_done_cyc);
                        check("ops_left_at_done", exp_q.size(), 0);
`ifdef NTT_SEQ_STALL_CNT_EN
                        check("stall_cnt", 64'(stall_cnt), stall_model);
`endif
                    end
                    exp_done_cyc = -1;
                    done_seen++;
                end
            end
        end
    end

    task automatic run(input logic [6:0] b, input int n, input bit rnd, input bit pokes);
        int ds0;
        int guard;
        rdy_rand = rnd;
        ds0      = done_seen;
        @(posedge clk);
        #1;
        push_run(b, n);
        base_addr     = b;
        count         = 8'(n);
        start         = 1'b1;
        stall_model   = 0;
        first_seen    = 1'b0;
        exp_first_cyc = (n == 0) ? -1 : cyc + 3;
        exp_done_cyc  = rnd ? -2 : ((n == 0) ? cyc + 1 : cyc + 3 + 2 * n);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 7'($urandom);
        count     = 8'($urandom);
        if (pokes) begin
            // WAIT/LOAD/ISSUE0 only: a run of 2+ words cannot be back in IDLE yet.
            repeat (3) begin
                start     = 1'($urandom_range(0, 1));
                base_addr = 7'($urandom);
                count     = 8'($urandom);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end
        guard = 0;
        while (done_seen == ds0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        if (done_seen == ds0)
            fail_now("timeout_waiting_done");
        if (n == 0)
            check("no_valid_for_zero_count", first_seen, 0);
        exp_q.delete();
        rdy_rand = 1'b0;
    endtask

    initial begin
        int guard;
        logic [6:0] rb;
        int rn;
        bit rr;
        for (int i = 0; i < 128; i++) rom[i] = {$urandom, $urandom};
        rom[7'h00] = {4'hA, 12'h745, 8'h00, 8'h10, 4'h5, 12'hC56, 8'h00, 8'h10};
        rom[7'h7F] = {4'h0, 12'h0AB, 8'hEF, 8'hFF, 4'h0, 12'h5BC, 8'hEF, 8'hFF};
        for (int i = 0; i < 4; i++)
            rom[7'h10 + 7'(i)] = {4'hF, 12'h5C2, 8'h20 + 8'(i), 8'h40 + 8'(i),
                                  4'hF, 12'h26E, 8'h20 + 8'(i), 8'h50 + 8'(i)};
        rom[7'h30] = {4'h0, 12'h93F, 8'h60, 8'h70, 4'h0, 12'h0B6, 8'h60, 8'h70};

        srst      = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bf_valid", bf_valid, 0);
        check("rst_bf_fields", {bf_lane, bf_zeta, bf_idx_a, bf_idx_b, bf_last}, 0);
        check("rst_rom_addr", rom_addr, 0);
`ifdef NTT_SEQ_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        srst = 1'b0;

        run(7'h00, 1, 1'b0, 1'b0);
        run(7'h7F, 2, 1'b0, 1'b0);
        run(7'h10, 4, 1'b1, 1'b1);
        run(7'h22, 0, 1'b0, 1'b0);
        run(7'h05, 255, 1'b0, 1'b0);

        // Reset in the middle of a 16-word run, on a lower-half op
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        push_run(7'h40, 16);
        base_addr    = 7'h40;
        count        = 8'd16;
        start        = 1'b1;
        first_seen   = 1'b0;
        exp_first_cyc = -1;
        exp_done_cyc = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bf_valid && bf_lane && exp_q.size() < 28) && guard < 100);
        if (guard >= 100)
            fail_now("timeout_waiting_issue1");
        srst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_bf_valid", bf_valid, 0);
        check("midrst_rom_addr", rom_addr, 0);
`ifdef NTT_SEQ_STALL_CNT_EN
        check("midrst_stall_cnt", stall_cnt, 0);
`endif
        srst = 1'b0;
        exp_q.delete();
        stall_model = 0;
        run(7'h30, 1, 1'b0, 1'b0);

        repeat (12) begin
            rb = 7'($urandom);
            rn = int'($urandom_range(0, 9));
            rr = 1'($urandom_range(0, 1));
            run(rb, rn, rr, (rn >= 2) && ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
